pic_fetch_branch: RTL and testbench
===================================

// Module: pic_fetch_branch
// PURPOSE
//  Instruction fetch/branch stage next to the program counter. Drives instruction-memory address from pc,
//  captures the 12-bit word into the instruction register (IR), decodes GOTO/CALL/RETLW and skip
//  instructions, keeps the 2-level return stack, and returns goto_addr/goto_enable/skip to the PC.
//  IR is exported to the execute datapath; one instruction per 4-phase (q1..q4) cycle, no prefetch.
// PARAMETERS
//  L2_PIC_INSTR_MEM_DEPTH  9   program address width (pc, goto_addr, stack entries)
//  PIC_INSTR_WIDTH         12  instruction word width
//  PIC_STACK_DEPTH         2   return stack levels (baseline core: fixed 2)
// PORTS
//  clk          in   1    core clock
//  rst          in   1    reset, asynchronous, active-low
//  q1,q2,q3,q4  in   1    one-hot phase ring from program counter
//  pc           in   L2   current instruction address
//  imem_addr    out  L2   instruction memory address (= pc, combinational)
//  imem_rdata   in   12   sync-read memory data, valid while q2 high
//  skip_cond    in   1    datapath skip condition for current instr (valid by q4)
//  ir           out  12   instruction register to execute datapath
//  goto_addr    out  L2   branch target to PC
//  goto_enable  out  1    load goto_addr at q4 edge
//  skip         out  1    PC advances by 2 at q4 edge
//  stack_err    out  1    sticky stack over/underflow (only with PIC_STACK_ERR_EN)
// BEHAVIOUR
//  Reset (rst low, async): ir=12'h000 (NOP), stack levels=0, depth count=0, stack_err=0.
//   goto_enable=skip=0 follow from NOP decode; goto_addr=0.
//  IR: loaded from imem_rdata on the clk edge where q2=1; holds otherwise. Decode from q3 onward.
//  Decode (combinational from ir, exclusive):
//   GOTO  101k_kkkk_kkkk: goto_enable=1, goto_addr=k[8:0] resized to L2 (upper bits dropped/zero).
//   CALL  1001_kkkk_kkkk: goto_enable=1, goto_addr={0,k[7:0]} (bit 8 always 0); push pc+1.
//   RETLW 1000_kkkk_kkkk: goto_enable=1, goto_addr=TOS; pop. Literal k taken by datapath from ir.
//   BTFSC 0110_*, BTFSS 0111_*, DECFSZ 0010_11*, INCFSZ 0011_11*: skip=skip_cond.
//   All other codes: goto_enable=0, skip=0.
//  Outputs meaningful q3..q4; PC samples only at q4 edge; values during q1/q2 are don't-care.
//  Stack: updated only on the clk edge where q4=1, at most one push or pop per instruction.
//   Push: L2<=L1, L1<=pc+1 (mod 2^L2, pc=max wraps to 0). Old L2 lost silently (overflow).
//   Pop: TOS=L1 drives goto_addr; L1<=L2, L2 unchanged (underflow returns L2 repeatedly).
//   Depth count 0..2 saturating: push +1, pop -1; used only for error detect.
//  Latency: fetch q2 edge -> decode valid q3 -> PC update q4 edge; 4 clk per instruction.
//  Reset mid-cycle: all state cleared immediately; no partial push/pop survives.
// CONFIGURATION
//  PIC_STACK_ERR_EN defined: stack_err port present; set on push at depth 2 or pop at depth 0,
//   sticky until reset. Not defined: port absent, no depth counter; stack behaviour identical.
// STRUCTURE
//  Opcode masks/values (GOTO, CALL, RETLW, skip group, NOP) as localparams in shared pic_params.v.
//  Sub-module pic_return_stack: push/pop/data_in -> tos, 2 levels, holds PIC_STACK_ERR_EN logic.
//  Top: IR register, opcode decode, target muxing, imem_addr wire.
// TESTING
//  Reset: rst low mid-q3 with ir=GOTO -> ir=0, goto_enable=0 at once; stack reads 0.
//  GOTO 12'hA55 at pc=3 -> goto_enable=1, goto_addr=9'h055 through q3..q4; no stack change.
//  CALL 12'h910 at pc=9'h1FF -> goto_addr=9'h010; L1=0 (wrap); RETLW next -> goto_addr=0.
//  3 nested CALLs from pc 10,20,30 then 3 RETLW -> targets 31,21,21; stack_err=1 if enabled.
//  BTFSC with skip_cond=1 -> skip=1 at q4; skip_cond=0 -> skip=0; ADDWF with skip_cond=1 -> skip=0.
//  RETLW from empty stack after reset -> goto_addr=0; stack_err=1 with macro, port absent without.

Source files
------------

// File: rtl/pic_fetch_branch_pkg.sv
// Shared opcode masks/values and the instruction classifier for the
// PIC baseline fetch/branch stage.
package pic_fetch_branch_pkg;

  // Reset value of the instruction register: NOP.
  localparam logic [11:0] OP_NOP        = 12'h000;

  // GOTO 101k_kkkk_kkkk
  localparam logic [11:0] OP_GOTO_MASK  = 12'hE00;
  localparam logic [11:0] OP_GOTO_VAL   = 12'hA00;
  // CALL 1001_kkkk_kkkk
  localparam logic [11:0] OP_CALL_MASK  = 12'hF00;
  localparam logic [11:0] OP_CALL_VAL   = 12'h900;
  // RETLW 1000_kkkk_kkkk
  localparam logic [11:0] OP_RETLW_MASK = 12'hF00;
  localparam logic [11:0] OP_RETLW_VAL  = 12'h800;
  // Skip group: BTFSC 0110_*, BTFSS 0111_*, DECFSZ 0010_11*, INCFSZ 0011_11*
  localparam logic [11:0] OP_BTFSC_MASK  = 12'hF00;
  localparam logic [11:0] OP_BTFSC_VAL   = 12'h600;
  localparam logic [11:0] OP_BTFSS_MASK  = 12'hF00;
  localparam logic [11:0] OP_BTFSS_VAL   = 12'h700;
  localparam logic [11:0] OP_DECFSZ_MASK = 12'hFC0;
  localparam logic [11:0] OP_DECFSZ_VAL  = 12'h2C0;
  localparam logic [11:0] OP_INCFSZ_MASK = 12'hFC0;
  localparam logic [11:0] OP_INCFSZ_VAL  = 12'h3C0;

  // Decoded class of the instruction sitting in IR.
  typedef enum logic [2:0] {
    INSTR_OTHER = 3'd0,
    INSTR_GOTO  = 3'd1,
    INSTR_CALL  = 3'd2,
    INSTR_RETLW = 3'd3,
    INSTR_SKIP  = 3'd4
  } instr_class_e;

  // Classify a 12-bit instruction word; the opcode groups never overlap.
  function automatic instr_class_e classify_instr(input logic [11:0] word);
    instr_class_e cls;
    if ((word & OP_GOTO_MASK) == OP_GOTO_VAL) begin
      cls = INSTR_GOTO;
    end else if ((word & OP_CALL_MASK) == OP_CALL_VAL) begin
      cls = INSTR_CALL;
    end else if ((word & OP_RETLW_MASK) == OP_RETLW_VAL) begin
      cls = INSTR_RETLW;
    end else if (((word & OP_BTFSC_MASK)  == OP_BTFSC_VAL)  ||
                 ((word & OP_BTFSS_MASK)  == OP_BTFSS_VAL)  ||
                 ((word & OP_DECFSZ_MASK) == OP_DECFSZ_VAL) ||
                 ((word & OP_INCFSZ_MASK) == OP_INCFSZ_VAL)) begin
      cls = INSTR_SKIP;
    end else begin
      cls = INSTR_OTHER;
    end
    return cls;
  endfunction

endpackage

// File: rtl/pic_fetch_branch_return_stack.sv
// Two-level return-address stack for the PIC fetch/branch stage.
// Push shifts L1 into L2 (old L2 is lost); pop moves L2 into L1 and leaves
// L2 unchanged, so repeated underflow keeps returning L2.
// Optional feature macro: PIC_STACK_ERR_EN adds a saturating depth counter
// and a sticky stack_err flag for overflow/underflow.
module pic_fetch_branch_return_stack #(
  parameter int AW    = 9,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] data_in,
  output logic [AW-1:0] tos
`ifdef PIC_STACK_ERR_EN
  ,
  output logic          stack_err
`endif
);

  logic [AW-1:0] level1_r;
  logic [AW-1:0] level2_r;

  // Shift return addresses in on push and out on pop; hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level1_r <= {AW{1'b0}};
      level2_r <= {AW{1'b0}};
    end else if (push) begin
      level2_r <= level1_r;
      level1_r <= data_in;
    end else if (pop) begin
      level1_r <= level2_r;
      level2_r <= level2_r;
    end else begin
      level1_r <= level1_r;
      level2_r <= level2_r;
    end
  end

  assign tos = level1_r;

`ifdef PIC_STACK_ERR_EN
  localparam logic [1:0] DEPTH_MAX = 2'(DEPTH);

  logic [1:0] depth_r;
  logic       err_r;

  // Track occupancy (saturating) and latch any push-when-full or pop-when-empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_r <= 2'd0;
      err_r   <= 1'b0;
    end else if (push) begin
      if (depth_r == DEPTH_MAX) begin
        depth_r <= depth_r;
        err_r   <= 1'b1;
      end else begin
        depth_r <= depth_r + 2'd1;
        err_r   <= err_r;
      end
    end else if (pop) begin
      if (depth_r == 2'd0) begin
        depth_r <= depth_r;
        err_r   <= 1'b1;
      end else begin
        depth_r <= depth_r - 2'd1;
        err_r   <= err_r;
      end
    end else begin
      depth_r <= depth_r;
      err_r   <= err_r;
    end
  end

  assign stack_err = err_r;
`else
  // Depth is only needed for error detection, which is not built here.
  logic unused_depth_s;
  assign unused_depth_s = (DEPTH == 2);
`endif

endmodule

// File: rtl/pic_fetch_branch.sv
// PIC baseline instruction fetch/branch stage: IR capture at q2, opcode
// decode from q3, GOTO/CALL/RETLW target muxing, skip request, and the
// return stack (updated at the q4 edge).
// Optional feature macro: PIC_STACK_ERR_EN exposes the sticky stack_err port.
module pic_fetch_branch #(
  parameter int L2_PIC_INSTR_MEM_DEPTH = 9,
  parameter int PIC_INSTR_WIDTH        = 12,
  parameter int PIC_STACK_DEPTH        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              q1,
  input  logic                              q2,
  input  logic                              q3,
  input  logic                              q4,
  input  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] pc,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] imem_addr,
  input  logic [PIC_INSTR_WIDTH-1:0]        imem_rdata,
  input  logic                              skip_cond,
  output logic [PIC_INSTR_WIDTH-1:0]        ir,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] goto_addr,
  output logic                              goto_enable,
  output logic                              skip
`ifdef PIC_STACK_ERR_EN
  ,
  output logic                              stack_err
`endif
);

  import pic_fetch_branch_pkg::*;

  localparam int AW = L2_PIC_INSTR_MEM_DEPTH;

  logic [PIC_INSTR_WIDTH-1:0] ir_r;
  instr_class_e               cls_s;
  logic [AW-1:0]              tos_s;
  logic [AW-1:0]              ret_addr_s;
  logic [AW-1:0]              goto_addr_s;
  logic                       goto_enable_s;
  logic                       skip_s;
  logic                       push_s;
  logic                       pop_s;

  // q1/q3 carry no event of their own here: decode is combinational from IR.
  logic unused_phase_s;
  assign unused_phase_s = q1 ^ q3;

  // No prefetch: memory is addressed straight from the PC.
  assign imem_addr = pc;

  // Capture the fetched word on the q2 edge and hold it for the rest of the cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_r <= OP_NOP;
    end else if (q2) begin
      ir_r <= imem_rdata;
    end else begin
      ir_r <= ir_r;
    end
  end

  assign ir    = ir_r;
  assign cls_s = classify_instr(ir_r);

  // Return address wraps naturally at the top of program memory.
  assign ret_addr_s = pc + AW'(1);

  // Decode IR into branch target, branch/skip requests and stack operations.
  always_comb begin
    goto_enable_s = 1'b0;
    goto_addr_s   = {AW{1'b0}};
    skip_s        = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    case (cls_s)
      INSTR_GOTO: begin
        goto_enable_s = 1'b1;
        goto_addr_s   = AW'(ir_r[8:0]);
      end
      INSTR_CALL: begin
        // CALL can only reach the lower half page: target bit 8 is forced to 0.
        goto_enable_s = 1'b1;
        goto_addr_s   = AW'({1'b0, ir_r[7:0]});
        push_s        = q4;
      end
      INSTR_RETLW: begin
        goto_enable_s = 1'b1;
        goto_addr_s   = tos_s;
        pop_s         = q4;
      end
      INSTR_SKIP: begin
        skip_s = skip_cond;
      end
      INSTR_OTHER: begin
        goto_enable_s = 1'b0;
      end
      default: begin
        goto_enable_s = 1'b0;
      end
    endcase
  end

  assign goto_enable = goto_enable_s;
  assign goto_addr   = goto_addr_s;
  assign skip        = skip_s;

  pic_fetch_branch_return_stack #(
    .AW    (AW),
    .DEPTH (PIC_STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .data_in   (ret_addr_s),
    .tos       (tos_s)
`ifdef PIC_STACK_ERR_EN
    ,
    .stack_err (stack_err)
`endif
  );

endmodule

// File: tb/tb_pic_fetch_branch.sv
// Directed bench for pic_fetch_branch. Drives the q1..q4 phase ring one
// clock per phase, supplies instruction words, and compares decode outputs
// and stack behaviour against hand-computed values.
// Honours PIC_STACK_ERR_EN for the optional stack_err port.
module tb_pic_fetch_branch;

  logic        clk;
  logic        rst;
  logic        q1, q2, q3, q4;
  logic [8:0]  pc;
  logic [8:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic        skip_cond;
  logic [11:0] ir;
  logic [8:0]  goto_addr;
  logic        goto_enable;
  logic        skip;
`ifdef PIC_STACK_ERR_EN
  logic        stack_err;
`endif

  int vec_count  = 0;
  int fail_count = 0;

  // Samples taken mid-q3 and mid-q4 of the last instruction run.
  logic        q3_ge, q3_sk, q4_ge, q4_sk;
  logic [8:0]  q3_ga, q4_ga, q4_ia;
  logic [11:0] q3_ir;

  // Skip-group table: word, skip_cond, expected skip.
  logic [11:0] sk_word [8] = '{12'h6A3, 12'h6A3, 12'h7A3, 12'h2C5,
                               12'h3C5, 12'h1C5, 12'h205, 12'h0C5};
  logic        sk_cond [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        sk_exp  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  pic_fetch_branch dut (
    .clk         (clk),
    .rst         (rst),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .q4          (q4),
    .pc          (pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .skip_cond   (skip_cond),
    .ir          (ir),
    .goto_addr   (goto_addr),
    .goto_enable (goto_enable),
    .skip        (skip)
`ifdef PIC_STACK_ERR_EN
    ,
    .stack_err   (stack_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is purely clock-driven, so this never fires normally.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_phase(input int p);
    q1 = (p == 1);
    q2 = (p == 2);
    q3 = (p == 3);
    q4 = (p == 4);
  endtask

  // One full q1..q4 instruction; ends just after the q4 edge.
  task automatic run_instr(input logic [8:0] pc_v, input logic [11:0] word, input logic sc);
    @(negedge clk);
    pc = pc_v; imem_rdata = word; skip_cond = sc; set_phase(1);
    @(negedge clk);
    set_phase(2);
    @(negedge clk);
    set_phase(3);
    #1;
    q3_ge = goto_enable; q3_ga = goto_addr; q3_sk = skip; q3_ir = ir;
    @(negedge clk);
    set_phase(4);
    #1;
    q4_ge = goto_enable; q4_ga = goto_addr; q4_sk = skip; q4_ia = imem_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; set_phase(0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; set_phase(0);
    pc = 9'h000; imem_rdata = 12'h000; skip_cond = 1'b0;
    #3;
    check_vec("rst_ir", 16'(ir), 16'h000);
    check_vec("rst_ge", 16'(goto_enable), 16'h0);
    check_vec("rst_skip", 16'(skip), 16'h0);
    check_vec("rst_ga", 16'(goto_addr), 16'h000);
`ifdef PIC_STACK_ERR_EN
    check_vec("rst_err", 16'(stack_err), 16'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // RETLW from empty stack returns 0.
    run_instr(9'h005, 12'h8AB, 1'b0);
    check_vec("retlw_empty_ge", 16'(q4_ge), 16'h1);
    check_vec("retlw_empty_ga", 16'(q4_ga), 16'h000);
`ifdef PIC_STACK_ERR_EN
    check_vec("underflow_err", 16'(stack_err), 16'h1);
`endif

    // Put something on the stack, then reset mid-q3 of a GOTO.
    run_instr(9'h0FF, 12'h9C0, 1'b0);
    check_vec("call_pre_rst_ga", 16'(q4_ga), 16'h0C0);
    @(negedge clk);
    pc = 9'h003; imem_rdata = 12'hA55; set_phase(1);
    @(negedge clk);
    set_phase(2);
    @(negedge clk);
    set_phase(3);
    #1;
    check_vec("pre_rst_ge", 16'(goto_enable), 16'h1);
    #1;
    rst = 1'b0;
    #1;
    check_vec("midrst_ir", 16'(ir), 16'h000);
    check_vec("midrst_ge", 16'(goto_enable), 16'h0);
    check_vec("midrst_ga", 16'(goto_addr), 16'h000);
`ifdef PIC_STACK_ERR_EN
    check_vec("midrst_err", 16'(stack_err), 16'h0);
`endif
    @(negedge clk);
    set_phase(0);
    @(negedge clk);
    rst = 1'b1;
    // Stack was cleared: RETLW returns 0, not 0x100.
    run_instr(9'h010, 12'h800, 1'b0);
    check_vec("post_rst_tos", 16'(q4_ga), 16'h000);

    do_reset();
    // CALL, then GOTOs must not disturb the stack.
    run_instr(9'h040, 12'h923, 1'b0);
    check_vec("call40_ga", 16'(q4_ga), 16'h023);
    run_instr(9'h003, 12'hA55, 1'b0);
    check_vec("goto_q3_ge", 16'(q3_ge), 16'h1);
    check_vec("goto_q3_ga", 16'(q3_ga), 16'h055);
    check_vec("goto_q3_ir", 16'(q3_ir), 16'hA55);
    check_vec("goto_q4_ge", 16'(q4_ge), 16'h1);
    check_vec("goto_q4_ga", 16'(q4_ga), 16'h055);
    check_vec("goto_q4_skip", 16'(q4_sk), 16'h0);
    check_vec("goto_imem", 16'(q4_ia), 16'h003);
    run_instr(9'h004, 12'hBFF, 1'b1);
    check_vec("goto_b8_ga", 16'(q4_ga), 16'h1FF);
    run_instr(9'h056, 12'h8FF, 1'b0);
    check_vec("retlw_41", 16'(q4_ga), 16'h041);

    // CALL from the top of memory wraps the return address to 0.
    run_instr(9'h100, 12'h930, 1'b0);
    run_instr(9'h1FF, 12'h910, 1'b0);
    check_vec("call_wrap_ga", 16'(q4_ga), 16'h010);
    check_vec("call_wrap_imem", 16'(q4_ia), 16'h1FF);
    run_instr(9'h010, 12'h801, 1'b0);
    check_vec("ret_wrap", 16'(q4_ga), 16'h000);
    run_instr(9'h000, 12'h802, 1'b0);
    check_vec("ret_101", 16'(q4_ga), 16'h101);
`ifdef PIC_STACK_ERR_EN
    check_vec("balanced_err", 16'(stack_err), 16'h0);
`endif

    // Three nested CALLs overflow the 2-level stack.
    do_reset();
    run_instr(9'd10, 12'h914, 1'b0);
    check_vec("nest1_ga", 16'(q4_ga), 16'h014);
    run_instr(9'd20, 12'h91E, 1'b0);
    check_vec("nest2_ga", 16'(q4_ga), 16'h01E);
`ifdef PIC_STACK_ERR_EN
    check_vec("nest2_err", 16'(stack_err), 16'h0);
`endif
    run_instr(9'd30, 12'h928, 1'b0);
    check_vec("nest3_ga", 16'(q4_ga), 16'h028);
`ifdef PIC_STACK_ERR_EN
    check_vec("overflow_err", 16'(stack_err), 16'h1);
`endif
    run_instr(9'd40, 12'h800, 1'b0);
    check_vec("unwind1", 16'(q4_ga), 16'(9'd31));
    run_instr(9'd31, 12'h800, 1'b0);
    check_vec("unwind2", 16'(q4_ga), 16'(9'd21));
    run_instr(9'd21, 12'h800, 1'b0);
    check_vec("unwind3", 16'(q4_ga), 16'(9'd21));

    // Skip group and near-miss opcodes.
    for (int i = 0; i < 8; i++) begin
      run_instr(9'(i + 9'd100), sk_word[i], sk_cond[i]);
      check_vec($sformatf("skip_%0d", i), 16'(q4_sk), 16'(sk_exp[i]));
      check_vec($sformatf("skip_ge_%0d", i), 16'(q4_ge), 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
